exec_sequencer: RTL and testbench

- Multi-cycle execution sequencer for the single-issue core in EXEC mode.
- Each cycle it decides whether the current instruction may retire (PC advance) and when its result may be written back.
- Covers fixed-latency units (LW/LW_S: 1 extra cycle; fdiv/fsqrt: 3 extra cycles) and UART IN/OUT handshake stalls.
- Replaces the ad-hoc stage counter. Adds a stall-cycle counter and an I/O watchdog flag for LED debug.

---
 rtl/exec_sequencer.sv | 132 +++++++++++++
 tb/tb_exec_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle execution sequencer: decides retire (advance) and writeback per cycle
// for fixed-latency ops and UART I/O handshakes, with stall counter and I/O watchdog.
module exec_sequencer #(
  parameter int unsigned LAT_W      = 2,
  parameter int unsigned STALL_W    = 32,
  parameter int unsigned IO_TIMEOUT = 2**24
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               issue,
  input  logic [LAT_W-1:0]   lat,
  input  logic               io_req,
  input  logic               io_ok,
  input  logic               flush,
  output logic               advance,
  output logic               wb_en,
  output logic [LAT_W-1:0]   stage,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               io_timeout
);

  localparam int unsigned WAIT_W = $clog2(IO_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULTI  = 2'd1,
    IOWAIT = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [LAT_W-1:0]    stage_n, lat_q, lat_q_n;
  logic [WAIT_W-1:0]   io_wait_cnt, wait_n;
  logic [STALL_W-1:0]  stall_n;
  logic                tmo_n;

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      stage       <= '0;
      lat_q       <= '0;
      io_wait_cnt <= '0;
      stall_cnt   <= '0;
      io_timeout  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      stage       <= stage_n;
      lat_q       <= lat_q_n;
      io_wait_cnt <= wait_n;
      stall_cnt   <= stall_n;
      io_timeout  <= tmo_n;
      busy        <= (state_n == MULTI);
    end
  end

  // Next-state, retire and writeback decisions
  always_comb begin
    state_n = state;
    stage_n = stage;
    lat_q_n = lat_q;
    wait_n  = io_wait_cnt;
    tmo_n   = io_timeout;
    stall_n = stall_cnt;
    advance = 1'b0;
    wb_en   = 1'b0;

    // An explicit flush, or issue vanishing mid-op, aborts without writeback
    if (flush || (state != IDLE && !issue)) begin
      state_n = IDLE;
      stage_n = '0;
      wait_n  = '0;
      tmo_n   = 1'b0;
    end else begin
      case (state)
        IDLE, IOWAIT: begin
          if (issue) begin
            if (io_req) begin
              advance = io_ok;
              wb_en   = io_ok;
              if (io_ok) begin
                state_n = IDLE;
                wait_n  = '0;
              end else begin
                state_n = IOWAIT;
                if (io_wait_cnt != WAIT_W'(IO_TIMEOUT))
                  wait_n = io_wait_cnt + WAIT_W'(1);
                if (wait_n == WAIT_W'(IO_TIMEOUT))
                  tmo_n = 1'b1;
              end
            end else if (lat == '0) begin
              advance = 1'b1;
              wb_en   = 1'b1;
              state_n = IDLE;
              wait_n  = '0;
            end else begin
              lat_q_n = lat;
              stage_n = LAT_W'(1);
              state_n = MULTI;
              wait_n  = '0;
            end
          end
        end
        MULTI: begin
          if (stage == lat_q) begin
            advance = 1'b1;
            wb_en   = 1'b1;
            state_n = IDLE;
            stage_n = '0;
          end else begin
            stage_n = stage + LAT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          stage_n = '0;
        end
      endcase
    end

    if (issue && !advance && !flush)
      stall_n = stall_cnt + STALL_W'(1);

    // Reset overrides retire even though the registers only clear at the edge
    if (RST) begin
      advance = 1'b0;
      wb_en   = 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (IO_TIMEOUT shortened to 4).
module tb_exec_sequencer;

  localparam int unsigned LAT_W   = 2;
  localparam int unsigned STALL_W = 32;

  logic               CLK = 1'b0;
  logic               RST;
  logic               issue;
  logic [LAT_W-1:0]   lat;
  logic               io_req;
  logic               io_ok;
  logic               flush;
  logic               advance;
  logic               wb_en;
  logic [LAT_W-1:0]   stage;
  logic               busy;
  logic [STALL_W-1:0] stall_cnt;
  logic               io_timeout;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  logic [4:0] obs, exp_v;

  exec_sequencer #(.LAT_W(LAT_W), .STALL_W(STALL_W), .IO_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .issue(issue), .lat(lat), .io_req(io_req),
    .io_ok(io_ok), .flush(flush), .advance(advance), .wb_en(wb_en),
    .stage(stage), .busy(busy), .stall_cnt(stall_cnt), .io_timeout(io_timeout)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle's inputs at the falling edge, settle, then observe
  task automatic cyc(input logic r, input logic i, input logic [LAT_W-1:0] l,
                     input logic q, input logic o, input logic f);
    @(negedge CLK);
    RST = r; issue = i; lat = l; io_req = q; io_ok = o; flush = f;
    #1;
    obs = {advance, wb_en, stage, busy};
  endtask

  task automatic test_reset;
    cyc(1, 1, 2'd0, 0, 0, 0);
    checks++;
    if (advance !== 1'b0) begin
      errors++; $display("FAIL reset_advance: got %b want 0", advance);
    end
    cyc(0, 0, 2'd0, 0, 0, 0);
    checks++;
    if ({obs, io_timeout} !== 6'b0 || stall_cnt !== 0) begin
      errors++;
      $display("FAIL reset_state: got obs=%b tmo=%b stall=%0d want 0", obs, io_timeout, stall_cnt);
    end
  endtask

  task automatic test_single_cycle;
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 2'd0, 0, 0, 0);
      checks++;
      if (obs !== 5'b11_00_0) begin
        errors++; $display("FAIL single_c%0d: got %b want 11000", k, obs);
      end
    end
    cyc(0, 0, 2'd0, 0, 0, 0);
    checks++;
    if (stall_cnt !== 0) begin
      errors++; $display("FAIL single_stall: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_lw;
    logic [4:0] tbl [3];
    tbl[0] = 5'b00_00_0; tbl[1] = 5'b11_01_1; tbl[2] = 5'b00_00_0;
    for (int k = 0; k < 3; k++) begin
      cyc(0, k < 2, 2'd1, 0, 0, 0);
      checks++;
      if (obs !== tbl[k]) begin
        errors++; $display("FAIL lw_c%0d: got %b want %b", k, obs, tbl[k]);
      end
    end
    exp_stall += 1;
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL lw_stall: got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_fdiv;
    logic [4:0] tbl [5];
    tbl[0] = 5'b00_00_0; tbl[1] = 5'b00_01_1; tbl[2] = 5'b00_10_1;
    tbl[3] = 5'b11_11_1; tbl[4] = 5'b00_00_0;
    for (int k = 0; k < 5; k++) begin
      cyc(0, k < 4, (k == 2) ? 2'd0 : 2'd3, 0, 0, 0);
      checks++;
      if (obs !== tbl[k]) begin
        errors++; $display("FAIL fdiv_c%0d: got %b want %b", k, obs, tbl[k]);
      end
    end
    exp_stall += 3;
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL fdiv_stall: got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_io_wait;
    for (int k = 0; k < 9; k++) begin
      cyc(0, k < 8, 2'd3, 1, k == 7, 0);
      exp_v = (k == 7) ? 5'b11_00_0 : 5'b00_00_0;
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL io_c%0d: got %b want %b", k, obs, exp_v);
      end
      checks++;
      if (io_timeout !== (k >= 4)) begin
        errors++; $display("FAIL io_tmo_c%0d: got %b want %b", k, io_timeout, k >= 4);
      end
    end
    exp_stall += 7;
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL io_stall: got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_flush;
    logic [4:0] tbl [4];
    tbl[0] = 5'b00_00_0; tbl[1] = 5'b00_01_1; tbl[2] = 5'b00_10_1; tbl[3] = 5'b11_00_0;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, (k == 3) ? 2'd0 : 2'd3, 0, 0, k == 2);
      checks++;
      if (obs !== tbl[k]) begin
        errors++; $display("FAIL flush_c%0d: got %b want %b", k, obs, tbl[k]);
      end
    end
    checks++;
    if (io_timeout !== 1'b0) begin
      errors++; $display("FAIL flush_tmo: got %b want 0", io_timeout);
    end
    cyc(0, 0, 2'd0, 0, 0, 0);
    exp_stall += 2;
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL flush_stall: got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_reset_mid_op;
    cyc(0, 1, 2'd1, 0, 0, 0);
    cyc(1, 1, 2'd1, 0, 0, 0);
    checks++;
    if (obs !== 5'b00_01_1) begin
      errors++; $display("FAIL rst_multi_cycle: got %b want 00011", obs);
    end
    cyc(0, 0, 2'd0, 0, 0, 0);
    checks++;
    if ({obs, io_timeout} !== 6'b0 || stall_cnt !== 0) begin
      errors++;
      $display("FAIL rst_multi_after: got obs=%b tmo=%b stall=%0d want 0", obs, io_timeout, stall_cnt);
    end
    for (int k = 0; k < 5; k++) cyc(0, 1, 2'd0, 1, 0, 0);
    checks++;
    if (io_timeout !== 1'b1) begin
      errors++; $display("FAIL rst_io_tmo_pre: got %b want 1", io_timeout);
    end
    cyc(1, 1, 2'd0, 1, 1, 0);
    checks++;
    if ({advance, wb_en} !== 2'b00) begin
      errors++; $display("FAIL rst_io_cycle: got %b want 00", {advance, wb_en});
    end
    cyc(0, 0, 2'd0, 0, 0, 0);
    checks++;
    if ({obs, io_timeout} !== 6'b0 || stall_cnt !== 0) begin
      errors++;
      $display("FAIL rst_io_after: got obs=%b tmo=%b stall=%0d want 0", obs, io_timeout, stall_cnt);
    end
  endtask

  initial begin
    RST = 1'b1; issue = 1'b0; lat = '0; io_req = 1'b0; io_ok = 1'b0; flush = 1'b0;
    test_reset;
    test_single_cycle;
    test_lw;
    test_fdiv;
    test_io_wait;
    test_flush;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
